// File: rtl/gpu_pkg.sv
// Shared GPU definitions: frame FSM states and frame geometry constants.
package gpu_pkg;

  // Frame FSM states for the display fetch path.
  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    DONE       = 2'd2
  } frame_state_e;

  localparam int HACT         = 800;
  localparam int VACT         = 600;
  localparam int PIX_PER_WORD = 16;
  localparam int FRAME_WORDS  = (HACT * VACT) / PIX_PER_WORD;

endpackage

// File: rtl/vram_prefetch_fifo.sv
// Display prefetch FIFO. The head word is held in a register so the pixel
// shifter sees a registered output; flush empties the FIFO synchronously.
module vram_prefetch_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  input  logic                   rd_en,
  output logic [DW-1:0]          head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [DW-1:0] DATA_ZERO = DW'(0);

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nx_s;
  logic [DW-1:0] head_r;
  logic [DW-1:0] head_nx_s;
  logic          valid_r;
  logic          pop_s;
  logic          push_s;

  // Qualify requests: a pop needs data, a push needs room or a same-cycle pop.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    if (flush) begin
      pop_s  = 1'b0;
      push_s = 1'b0;
    end else begin
      pop_s  = rd_en && (count_r != CNT_ZERO);
      push_s = wr_en && ((count_r != CNT_FULL) || pop_s);
    end
  end

  // Next head word: advance on pop, or capture the first word into an empty FIFO.
  always_comb begin
    head_nx_s = head_r;
    if (pop_s) begin
      if (count_r > CNT_ONE) begin
        head_nx_s = mem_r[rd_ptr_r + PTR_ONE];
      end else if (push_s) begin
        head_nx_s = wr_data;
      end else begin
        head_nx_s = head_r;
      end
    end else if (push_s && (count_r == CNT_ZERO)) begin
      head_nx_s = wr_data;
    end else begin
      head_nx_s = head_r;
    end
  end

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nx_s = count_r;
    if (flush) begin
      count_nx_s = CNT_ZERO;
    end else if (push_s && !pop_s) begin
      count_nx_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nx_s = count_r - CNT_ONE;
    end else begin
      count_nx_s = count_r;
    end
  end

  // Word storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy, registered head and valid flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      valid_r  <= 1'b0;
      head_r   <= DATA_ZERO;
    end else if (flush) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      valid_r  <= 1'b0;
    end else begin
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      count_r <= count_nx_s;
      valid_r <= (count_nx_s != CNT_ZERO);
      head_r  <= head_nx_s;
    end
  end

  assign head  = head_r;
  assign valid = valid_r;
  assign count = count_r;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display prefetch versus CPU accesses.
// Urgent display demand wins, then the CPU, then opportunistic prefetch.
module vram_arbiter
  import gpu_pkg::*;
#(
  parameter int AW          = 15,
  parameter int DW          = 16,
  parameter int FRAME_WORDS = gpu_pkg::FRAME_WORDS,
  parameter int DEPTH       = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          frame_start,
  input  logic          disp_pop,
  output logic [DW-1:0] disp_word,
  output logic          disp_valid,
  output logic          underrun,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_WORDS - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_ZERO = AW'(0);
  localparam logic [CW-1:0] OCC_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] OCC_LOW   = CW'(DEPTH / 2);
  localparam logic [DW-1:0] DATA_ZERO = DW'(0);

  frame_state_e  state_r;
  frame_state_e  state_nx_s;
  logic [AW-1:0] ptr_r;
  logic          pend1_r;
  logic          pend2_r;
  logic [CW-1:0] fifo_count_s;
  logic [CW-1:0] occ_s;
  logic          fifo_valid_s;
  logic [DW-1:0] fifo_head_s;
  logic          fetch_ok_s;
  logic          eligible_s;
  logic          urgent_s;
  logic          cpu_can_s;
  logic          grant_fetch_s;
  logic          grant_cpu_s;
  logic [AW-1:0] mem_addr_nx_s;
  logic [DW-1:0] mem_wdata_nx_s;
  logic          cpu_busy_r;
  logic          cpu_rd1_r;
  logic          cpu_rd2_r;
  logic          cpu_ack_r;
  logic [DW-1:0] cpu_rdata_r;
  logic          mem_en_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;
  logic          underrun_r;

  // Returning display reads land here; frame_start flushes and wins over a write.
  vram_prefetch_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .flush   (frame_start),
    .wr_en   (pend2_r),
    .wr_data (mem_rdata),
    .rd_en   (disp_pop),
    .head    (fifo_head_s),
    .valid   (fifo_valid_s),
    .count   (fifo_count_s)
  );

  // Grant one requester per cycle; occupancy counts in-flight display reads.
  always_comb begin
    occ_s         = fifo_count_s + {{(CW-1){1'b0}}, pend1_r} + {{(CW-1){1'b0}}, pend2_r};
    fetch_ok_s    = (state_r == ACTIVE) && !frame_start;
    eligible_s    = fetch_ok_s && (occ_s < OCC_FULL);
    urgent_s      = fetch_ok_s && (occ_s < OCC_LOW);
    cpu_can_s     = cpu_req && !cpu_busy_r;
    grant_fetch_s = 1'b0;
    grant_cpu_s   = 1'b0;
    if (urgent_s) begin
      grant_fetch_s = 1'b1;
    end else if (cpu_can_s) begin
      grant_cpu_s = 1'b1;
    end else if (eligible_s) begin
      grant_fetch_s = 1'b1;
    end else begin
      grant_fetch_s = 1'b0;
      grant_cpu_s   = 1'b0;
    end
    mem_addr_nx_s  = ADDR_ZERO;
    mem_wdata_nx_s = DATA_ZERO;
    if (grant_cpu_s) begin
      mem_addr_nx_s  = cpu_addr;
      mem_wdata_nx_s = cpu_we ? cpu_wdata : DATA_ZERO;
    end else if (grant_fetch_s) begin
      mem_addr_nx_s = ptr_r;
    end else begin
      mem_addr_nx_s  = ADDR_ZERO;
      mem_wdata_nx_s = DATA_ZERO;
    end
  end

  // Frame FSM next state: frame_start restarts from any state.
  always_comb begin
    state_nx_s = state_r;
    if (frame_start) begin
      state_nx_s = ACTIVE;
    end else begin
      case (state_r)
        WAIT_FRAME: state_nx_s = WAIT_FRAME;
        ACTIVE: begin
          if (grant_fetch_s && (ptr_r == LAST_ADDR)) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = ACTIVE;
          end
        end
        DONE:       state_nx_s = DONE;
        default:    state_nx_s = WAIT_FRAME;
      endcase
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= WAIT_FRAME;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Fetch pointer and display read pipeline; frame_start drops in-flight reads.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr_r   <= ADDR_ZERO;
      pend1_r <= 1'b0;
      pend2_r <= 1'b0;
    end else if (frame_start) begin
      ptr_r   <= ADDR_ZERO;
      pend1_r <= 1'b0;
      pend2_r <= 1'b0;
    end else begin
      if (grant_fetch_s && (ptr_r != LAST_ADDR)) begin
        ptr_r <= ptr_r + ADDR_ONE;
      end
      pend1_r <= grant_fetch_s;
      pend2_r <= pend1_r;
    end
  end

  // CPU tracking: one outstanding access, released at the end of its ack cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cpu_busy_r  <= 1'b0;
      cpu_rd1_r   <= 1'b0;
      cpu_rd2_r   <= 1'b0;
      cpu_ack_r   <= 1'b0;
      cpu_rdata_r <= DATA_ZERO;
    end else begin
      if (grant_cpu_s) begin
        cpu_busy_r <= 1'b1;
      end else if (cpu_ack_r) begin
        cpu_busy_r <= 1'b0;
      end
      cpu_rd1_r <= grant_cpu_s && !cpu_we;
      cpu_rd2_r <= cpu_rd1_r;
      cpu_ack_r <= (grant_cpu_s && cpu_we) || cpu_rd2_r;
      if (cpu_rd2_r) begin
        cpu_rdata_r <= mem_rdata;
      end
    end
  end

  // Registered RAM command issued the cycle after the grant.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= ADDR_ZERO;
      mem_wdata_r <= DATA_ZERO;
    end else begin
      mem_en_r    <= grant_fetch_s || grant_cpu_s;
      mem_we_r    <= grant_cpu_s && cpu_we;
      mem_addr_r  <= mem_addr_nx_s;
      mem_wdata_r <= mem_wdata_nx_s;
    end
  end

  // Sticky underrun: a pop against an empty FIFO.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      underrun_r <= 1'b0;
    end else if (disp_pop && !fifo_valid_s) begin
      underrun_r <= 1'b1;
    end
  end

  assign disp_word  = fifo_head_s;
  assign disp_valid = fifo_valid_s;
  assign underrun   = underrun_r;
  assign cpu_ack    = cpu_ack_r;
  assign cpu_rdata  = cpu_rdata_r;
  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: CPU vector table plus hand-written
// frame, priority, flush, underrun and reset sequences.
`timescale 1ns/1ps
module tb_vram_arbiter;
  import gpu_pkg::*;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int FW = 30000;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          frame_start = 1'b0;
  logic          disp_pop = 1'b0;
  logic [DW-1:0] disp_word;
  logic          disp_valid;
  logic          underrun;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    logic [DW-1:0] rdata;
  } cpu_vec_t;

  cpu_vec_t vecs[5];

  vram_arbiter #(.AW(AW), .DW(DW), .FRAME_WORDS(FW), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .frame_start(frame_start), .disp_pop(disp_pop),
    .disp_word(disp_word), .disp_valid(disp_valid), .underrun(underrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM contents are a fixed function of the address.
  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return {1'b0, a} ^ 16'hA5A5;
  endfunction

  // RAM model: read data one cycle after the strobe.
  always @(posedge clk) mem_rdata <= mem_en ? ram_word(mem_addr) : 16'h0000;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Issue one CPU access now (grant cycle t) and check command, latency, data.
  task automatic cpu_op(input string name, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int exp_lat, input logic [DW-1:0] exp_rd);
    int lat;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    cyc();
    check({name, "_mem_en"}, mem_en, 1);
    check({name, "_mem_we"}, mem_we, we);
    check({name, "_mem_addr"}, mem_addr, addr);
    if (we) check({name, "_mem_wdata"}, mem_wdata, wdata);
    lat = 1;
    while (!cpu_ack && lat < 10) begin
      cyc();
      lat++;
    end
    check({name, "_ack_lat"}, lat, exp_lat);
    if (!we) check({name, "_rdata"}, cpu_rdata, exp_rd);
    cpu_req = 1'b0;
    cyc();
    check({name, "_ack_pulse"}, cpu_ack, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int seen, hit, nfetch, addr_err, data_err, pop_idx, idle, lat;
    logic [AW-1:0] last_addr;
    logic en_s[10];
    logic [AW-1:0] addr_s[10];
    logic val_s[10];
    logic [DW-1:0] word4;

    vecs[0] = '{we: 1'b1, addr: 15'h1234, wdata: 16'hBEEF, lat: 1, rdata: 16'h0000};
    vecs[1] = '{we: 1'b0, addr: 15'h0000, wdata: 16'h0000, lat: 3, rdata: 16'hA5A5};
    vecs[2] = '{we: 1'b0, addr: 15'h7FFF, wdata: 16'h0000, lat: 3, rdata: 16'hDA5A};
    vecs[3] = '{we: 1'b1, addr: 15'h0001, wdata: 16'h0000, lat: 1, rdata: 16'h0000};
    vecs[4] = '{we: 1'b0, addr: 15'h1234, wdata: 16'h0000, lat: 3, rdata: 16'hB791};

    // Reset state
    repeat (3) cyc();
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_disp_word", disp_word, 0);
    check("rst_underrun", underrun, 0);
    clr = 1'b0;
    seen = 0;
    repeat (6) begin cyc(); if (mem_en) seen++; end
    check("no_fetch_before_frame", seen, 0);

    // CPU vector table while no frame is active
    for (int i = 0; i < 5; i++)
      cpu_op($sformatf("cpu%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].rdata);

    // Held request: next grant only after the ack cycle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0042; cpu_wdata = 16'h1111;
    cyc(); check("b2b_first_ack", cpu_ack, 1);
    cyc(); check("b2b_gap", mem_en, 0);
    cyc(); check("b2b_second_en", mem_en, 1); check("b2b_second_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    cyc(); check("b2b_done", mem_en, 0);

    // Frame start: four sequential fetches, then the FIFO is full
    frame_start = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      frame_start = 1'b0;
      en_s[i] = mem_en; addr_s[i] = mem_addr; val_s[i] = disp_valid;
      if (i == 4) word4 = disp_word;
    end
    check("fs_no_en_first", en_s[1], 0);
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("fs_en%0d", i - 2), en_s[i], 1);
      check($sformatf("fs_addr%0d", i - 2), addr_s[i], i - 2);
    end
    for (int i = 6; i <= 9; i++) check($sformatf("fs_full_idle%0d", i), en_s[i], 0);
    check("fs_valid_early", val_s[3], 0);
    check("fs_valid_rise", val_s[4], 1);
    check("fs_first_word", word4, 16'hA5A5);

    // CPU write under load: urgent fetch first, then the CPU write
    frame_start = 1'b1;
    cyc(); frame_start = 1'b0;
    check("load_flush_valid", disp_valid, 0);
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 16'hBEEF;
    cyc();
    check("load_fetch_en", mem_en, 1); check("load_fetch_we", mem_we, 0); check("load_fetch_addr", mem_addr, 1);
    cyc();
    check("load_cpu_we", mem_we, 1); check("load_cpu_addr", mem_addr, 15'h1234);
    check("load_cpu_wdata", mem_wdata, 16'hBEEF); check("load_cpu_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    cyc();
    check("load_next_fetch", mem_addr, 2); check("load_next_we", mem_we, 0); check("load_ack_low", cpu_ack, 0);

    // CPU read with the FIFO full
    repeat (8) cyc();
    check("full_idle", mem_en, 0);
    cpu_op("rd_full", 1'b0, 15'h0000, 16'h0000, 3, 16'hA5A5);

    // Frame restart at word 100
    hit = 0;
    for (int c = 0; c < 1000 && hit == 0; c++) begin
      cyc();
      disp_pop = 1'b0;
      if (mem_en && !mem_we && mem_addr == 15'd100) begin
        hit = 1;
        frame_start = 1'b1;
      end else if (disp_valid) begin
        disp_pop = 1'b1;
      end
    end
    check("w100_reached", hit, 1);
    cyc(); frame_start = 1'b0;
    check("w100_flushed", disp_valid, 0);
    lat = 0;
    while (!mem_en && lat < 10) begin cyc(); lat++; end
    check("w100_restart_addr", mem_addr, 0);
    lat = 0;
    while (!disp_valid && lat < 10) begin cyc(); lat++; end
    check("w100_first_word", disp_word, 16'hA5A5);

    // Whole frame, popping whenever a word is available
    frame_start = 1'b1;
    cyc(); frame_start = 1'b0;
    nfetch = 0; addr_err = 0; data_err = 0; pop_idx = 0; idle = 0; last_addr = '0;
    for (int c = 0; c < 40000 && idle < 20; c++) begin
      if (c > 0) cyc();
      if (mem_en && !mem_we) begin
        if (mem_addr != AW'(nfetch)) addr_err++;
        last_addr = mem_addr;
        nfetch++;
      end
      if (disp_valid) begin
        if (disp_word != ram_word(AW'(pop_idx))) data_err++;
        pop_idx++;
        disp_pop = 1'b1;
      end else begin
        disp_pop = 1'b0;
      end
      if (nfetch >= FW && !disp_valid) idle++;
      else idle = 0;
    end
    disp_pop = 1'b0;
    check("frame_fetches", nfetch, FW);
    check("frame_addr_seq", addr_err, 0);
    check("frame_last_addr", last_addr, FW - 1);
    check("frame_pops", pop_idx, FW);
    check("frame_data", data_err, 0);
    check("frame_done_state", dut.state_r, DONE);
    check("frame_no_underrun", underrun, 0);

    // Underrun: pop on an empty FIFO, sticky across frame_start
    cyc();
    check("ur_empty", disp_valid, 0);
    disp_pop = 1'b1;
    cyc(); disp_pop = 1'b0;
    check("ur_set", underrun, 1);
    check("ur_fifo_unchanged", disp_valid, 0);
    frame_start = 1'b1;
    cyc(); frame_start = 1'b0;
    repeat (3) cyc();
    check("ur_sticky", underrun, 1);
    check("ur_refill_valid", disp_valid, 1);
    check("ur_refill_word", disp_word, 16'hA5A5);

    // Reset in mid-activity with a CPU read outstanding
    repeat (4) cyc();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
    cyc();
    clr = 1'b1;
    cyc();
    cpu_req = 1'b0;
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_cpu_rdata", cpu_rdata, 0);
    check("mid_rst_disp_valid", disp_valid, 0);
    check("mid_rst_disp_word", disp_word, 0);
    check("mid_rst_underrun", underrun, 0);
    clr = 1'b0;
    seen = 0;
    repeat (8) begin cyc(); if (mem_en || cpu_ack) seen++; end
    check("mid_rst_quiet", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
